// File: rtl/coax_buffer.sv
// coax_buffer: first-word-fall-through FIFO for 10-bit coax words, with flags decoded only from the registered count.
// Latency: a word written into an empty FIFO shows on read_data one cycle later. A write while full and a read while empty are dropped.
// Optional sticky overflow/underflow flags are built only when COAX_BUFFER_ERROR_FLAGS_EN is defined.
module coax_buffer #(
  parameter int DEPTH                  = 16,
  parameter int ALMOST_EMPTY_THRESHOLD = 4,
  parameter int ALMOST_FULL_THRESHOLD  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] write_data,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [9:0] read_data,
  output logic       empty,
  output logic       full,
  output logic       almost_empty,
  output logic       almost_full,
  output logic       overflow,
  output logic       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_acc;
  logic          rd_acc;

  assign wr_acc = write_strobe && !full;
  assign rd_acc = read_strobe && !empty;

  // The storage array is not reset, so stale words may remain after a reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_THRESHOLD));
  assign almost_full  = (count >= CW'(ALMOST_FULL_THRESHOLD));
  assign read_data    = empty ? 10'd0 : mem[rd_ptr];

`ifdef COAX_BUFFER_ERROR_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_strobe && full) begin
        overflow <= 1'b1;
      end
      if (read_strobe && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_coax_buffer.sv
// Testbench for coax_buffer: a queue-based reference model of the FIFO feeds a scoreboard.
// A monitor running on the falling edge checks the flags, the head word and the order of consumed words.
module tb_coax_buffer;

  localparam int DEPTH = 16;
  localparam int AET   = 4;
  localparam int AFT   = 12;
`ifdef COAX_BUFFER_ERROR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] write_data = '0;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [9:0] read_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  coax_buffer #(.DEPTH(DEPTH), .ALMOST_EMPTY_THRESHOLD(AET), .ALMOST_FULL_THRESHOLD(AFT)) dut (
    .clk(clk), .reset(reset), .write_data(write_data), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .read_data(read_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: the FIFO contents, and the scoreboard of words expected to be consumed.
  logic [9:0] model_q[$];
  logic [9:0] exp_rd[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  // What the DUT should be presenting during the current cycle.
  int         cur_cnt = 0;
  bit         cur_ovf = 1'b0;
  bit         cur_udf = 1'b0;
  bit         cur_rd_acc = 1'b0;
  logic [9:0] cur_head = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle of stimulus. The model is advanced to the state reached after the next rising edge.
  task automatic step(input bit wr, input logic [9:0] d, input bit rd);
    @(posedge clk);
    #1;
    write_strobe = wr;
    write_data   = d;
    read_strobe  = rd;
    cur_cnt    = model_q.size();
    cur_ovf    = m_ovf;
    cur_udf    = m_udf;
    cur_head   = (cur_cnt != 0) ? model_q[0] : 10'd0;
    cur_rd_acc = rd && (cur_cnt != 0);
    if (ERR_EN && wr && cur_cnt == DEPTH) m_ovf = 1'b1;
    if (ERR_EN && rd && cur_cnt == 0) m_udf = 1'b1;
    if (cur_rd_acc) exp_rd.push_back(model_q.pop_front());
    if (wr && cur_cnt < DEPTH) model_q.push_back(d);
  endtask

  task automatic model_clear();
    model_q.delete();
    exp_rd.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    cur_cnt = 0; cur_ovf = 1'b0; cur_udf = 1'b0; cur_rd_acc = 1'b0; cur_head = '0;
  endtask

  // Assert reset between clock edges and check the outputs before the next edge arrives.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    model_clear();
    #1;
    check({tag, "_empty"},  int'(empty), 1);
    check({tag, "_full"},   int'(full), 0);
    check({tag, "_aempty"}, int'(almost_empty), 1);
    check({tag, "_afull"},  int'(almost_full), 0);
    check({tag, "_rdata"},  int'(read_data), 0);
    check({tag, "_ovf"},    int'(overflow), 0);
    check({tag, "_udf"},    int'(underflow), 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("empty",  int'(empty),        int'(cur_cnt == 0));
        check("full",   int'(full),         int'(cur_cnt == DEPTH));
        check("aempty", int'(almost_empty), int'(cur_cnt <= AET));
        check("afull",  int'(almost_full),  int'(cur_cnt >= AFT));
        check("head",   int'(read_data),    int'(cur_head));
        check("ovf",    int'(overflow),     int'(cur_ovf));
        check("udf",    int'(underflow),    int'(cur_udf));
        if (cur_rd_acc) begin
          if (exp_rd.size() == 0) check("sb_underrun", 1, 0);
          else check("rd_order", int'(read_data), int'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw;
    int pr;
    repeat (2) @(posedge clk);
    do_reset("rst");

    // Fill 0..15 with one idle cycle after each write.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 10'(i), 1'b0);
      step(1'b0, 10'd0, 1'b0);
    end
    // A write while full is dropped, with and without a simultaneous read.
    step(1'b1, 10'h3FF, 1'b0);
    step(1'b0, 10'd0, 1'b0);
    step(1'b1, 10'h3FE, 1'b1);
    step(1'b1, 10'h3FD, 1'b0);
    step(1'b0, 10'd0, 1'b0);
    // Drain until empty, then read once more while empty.
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 10'd0, 1'b1);
      step(1'b0, 10'd0, 1'b0);
    end
    step(1'b0, 10'd0, 1'b0);

    // Write 20 words while reading concurrently, so both pointers wrap.
    step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b1);
    step(1'b0, 10'd0, 1'b1);
    step(1'b0, 10'd0, 1'b0);

    // Random traffic: each block of 100 cycles leans towards filling, draining or staying balanced.
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 20 : 50;
      pr = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 100; i++)
        step(bit'($urandom_range(0, 99) < pw), 10'($urandom_range(0, 1023)),
             bit'($urandom_range(0, 99) < pr));
    end

    // Reset partway through a fill: all stored words are discarded.
    do_reset("rst_pre");
    for (int i = 0; i < 8; i++) step(1'b1, 10'(100 + i), 1'b0);
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) step(1'b1, 10'(200 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 10'd0, 1'b1);

    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 10'd0, 1'b1);
    step(1'b0, 10'd0, 1'b0);
    @(negedge clk);
    check("sb_drained", exp_rd.size(), 0);
    check("model_empty", int'(empty), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
